// File: rtl/control_unit.sv
// control_unit: multicycle control FSM for the MIPS-subset CPU.
// Walks each instruction through fetch/decode/execute/memory/writeback and
// drives every datapath enable, mux select, ALU control and mult/div start.
// Ports:
//   Clock, Reset        - rising-edge clock, asynchronous active-high reset
//   Opcode, Funct       - instruction fields from IR
//   Zero, Overflow      - ALU flags for the op driven this cycle
//   DivZero             - divisor is zero, looked at in DIV_START
//   MultDone, DivDone   - completion pulses, looked at only in the wait states
//   *Write/Mem*/IorD    - register and memory strobes
//   AluSrcA/B, AluCtl   - ALU operand selects and operation
//   MuxPC, MemToReg     - PC source and register write-data source
//   RegDst, ExcCode     - destination register select, exception cause
//   MultStart, DivStart - one-cycle start pulses
module control_unit (
  input  logic       Clock,
  input  logic       Reset,
  input  logic [5:0] Opcode,
  input  logic [5:0] Funct,
  input  logic       Zero,
  input  logic       Overflow,
  input  logic       DivZero,
  input  logic       MultDone,
  input  logic       DivDone,
  output logic       PCWrite,
  output logic       IRWrite,
  output logic       MemRead,
  output logic       MemWrite,
  output logic       RegWrite,
  output logic       WriteA,
  output logic       WriteB,
  output logic       WriteAluOut,
  output logic       MDRWrite,
  output logic       EPCWrite,
  output logic       HighWrite,
  output logic       LowWrite,
  output logic       IorD,
  output logic [1:0] AluSrcA,
  output logic [1:0] AluSrcB,
  output logic [2:0] AluCtl,
  output logic [2:0] MuxPC,
  output logic [2:0] MemToReg,
  output logic [1:0] RegDst,
  output logic [1:0] ExcCode,
  output logic       MultStart,
  output logic       DivStart
);

  localparam logic [4:0] RESET      = 5'd0;
  localparam logic [4:0] FETCH      = 5'd1;
  localparam logic [4:0] FETCH_WAIT = 5'd2;
  localparam logic [4:0] DECODE     = 5'd3;
  localparam logic [4:0] EXEC_R     = 5'd4;
  localparam logic [4:0] ALU_WB     = 5'd5;
  localparam logic [4:0] ADDI_EXEC  = 5'd6;
  localparam logic [4:0] ADDI_WB    = 5'd7;
  localparam logic [4:0] ADDR       = 5'd8;
  localparam logic [4:0] MEM_RD     = 5'd9;
  localparam logic [4:0] MEM_WAIT   = 5'd10;
  localparam logic [4:0] LW_WB      = 5'd11;
  localparam logic [4:0] MEM_WR     = 5'd12;
  localparam logic [4:0] BRANCH     = 5'd13;
  localparam logic [4:0] JUMP       = 5'd14;
  localparam logic [4:0] JAL        = 5'd15;
  localparam logic [4:0] JR         = 5'd16;
  localparam logic [4:0] LUI_WB     = 5'd17;
  localparam logic [4:0] MFHI       = 5'd18;
  localparam logic [4:0] MFLO       = 5'd19;
  localparam logic [4:0] MULT_START = 5'd20;
  localparam logic [4:0] MULT_WAIT  = 5'd21;
  localparam logic [4:0] DIV_START  = 5'd22;
  localparam logic [4:0] DIV_WAIT   = 5'd23;
  // One exception state per cause keeps ExcCode a pure function of state.
  localparam logic [4:0] EXC_OPC    = 5'd24;
  localparam logic [4:0] EXC_OVF    = 5'd25;
  localparam logic [4:0] EXC_DIV    = 5'd26;
  localparam logic [4:0] EXC_JUMP   = 5'd27;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_JR    = 6'h08;
  localparam logic [5:0] FN_MFHI  = 6'h10;
  localparam logic [5:0] FN_MFLO  = 6'h12;
  localparam logic [5:0] FN_MULT  = 6'h18;
  localparam logic [5:0] FN_DIV   = 6'h1A;
  localparam logic [5:0] FN_ADD   = 6'h20;
  localparam logic [5:0] FN_SUB   = 6'h22;
  localparam logic [5:0] FN_AND   = 6'h24;
  localparam logic [5:0] FN_SLT   = 6'h2A;

  logic [4:0] state_q, state_d;
  logic       funct_addsub;

  // Only add/sub trap on overflow; and/slt results are always committed.
  assign funct_addsub = (Funct == FN_ADD) || (Funct == FN_SUB);

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) state_q <= RESET;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = RESET;
    case (state_q)
      RESET:      state_d = FETCH;
      FETCH:      state_d = FETCH_WAIT;
      FETCH_WAIT: state_d = DECODE;
      DECODE: begin
        case (Opcode)
          OP_RTYPE: begin
            case (Funct)
              FN_ADD, FN_SUB, FN_AND, FN_SLT: state_d = EXEC_R;
              FN_JR:   state_d = JR;
              FN_MULT: state_d = MULT_START;
              FN_DIV:  state_d = DIV_START;
              FN_MFHI: state_d = MFHI;
              FN_MFLO: state_d = MFLO;
              default: state_d = EXC_OPC;
            endcase
          end
          OP_ADDI:       state_d = ADDI_EXEC;
          OP_BEQ, OP_BNE: state_d = BRANCH;
          OP_LW, OP_SW:  state_d = ADDR;
          OP_LUI:        state_d = LUI_WB;
          OP_J:          state_d = JUMP;
          OP_JAL:        state_d = JAL;
          default:       state_d = EXC_OPC;
        endcase
      end
      EXEC_R:     state_d = (funct_addsub && Overflow) ? EXC_OVF : ALU_WB;
      ADDI_EXEC:  state_d = Overflow ? EXC_OVF : ADDI_WB;
      ADDR:       state_d = (Opcode == OP_LW) ? MEM_RD : MEM_WR;
      MEM_RD:     state_d = MEM_WAIT;
      MEM_WAIT:   state_d = LW_WB;
      JAL:        state_d = JUMP;
      MULT_START: state_d = MULT_WAIT;
      MULT_WAIT:  state_d = MultDone ? FETCH : MULT_WAIT;
      DIV_START:  state_d = DivZero ? EXC_DIV : DIV_WAIT;
      DIV_WAIT:   state_d = DivDone ? FETCH : DIV_WAIT;
      EXC_OPC, EXC_OVF, EXC_DIV: state_d = EXC_JUMP;
      ALU_WB, ADDI_WB, LW_WB, MEM_WR, BRANCH, JUMP, JR, LUI_WB, MFHI, MFLO, EXC_JUMP:
        state_d = FETCH;
      default:    state_d = RESET;
    endcase
  end

  always_comb begin
    PCWrite     = 1'b0;
    IRWrite     = 1'b0;
    MemRead     = 1'b0;
    MemWrite    = 1'b0;
    RegWrite    = 1'b0;
    WriteA      = 1'b0;
    WriteB      = 1'b0;
    WriteAluOut = 1'b0;
    MDRWrite    = 1'b0;
    EPCWrite    = 1'b0;
    HighWrite   = 1'b0;
    LowWrite    = 1'b0;
    IorD        = 1'b0;
    AluSrcA     = 2'd0;
    AluSrcB     = 2'd0;
    AluCtl      = 3'd0;
    MuxPC       = 3'd0;
    MemToReg    = 3'd0;
    RegDst      = 2'd0;
    ExcCode     = 2'd0;
    MultStart   = 1'b0;
    DivStart    = 1'b0;
    case (state_q)
      FETCH: begin
        MemRead = 1'b1;
        AluSrcB = 2'd1;
        AluCtl  = 3'd1;
        PCWrite = 1'b1;
      end
      FETCH_WAIT: IRWrite = 1'b1;
      DECODE: begin
        WriteA      = 1'b1;
        WriteB      = 1'b1;
        WriteAluOut = 1'b1;
        AluSrcB     = 2'd3;
        AluCtl      = 3'd1;
      end
      EXEC_R: begin
        AluSrcA     = 2'd1;
        WriteAluOut = 1'b1;
        case (Funct)
          FN_SUB:  AluCtl = 3'd2;
          FN_AND:  AluCtl = 3'd3;
          FN_SLT:  AluCtl = 3'd7;
          default: AluCtl = 3'd1;
        endcase
      end
      ALU_WB: begin
        RegWrite = ~Overflow;
        RegDst   = 2'd1;
      end
      ADDI_EXEC, ADDR: begin
        AluSrcA     = 2'd1;
        AluSrcB     = 2'd2;
        AluCtl      = 3'd1;
        WriteAluOut = 1'b1;
      end
      ADDI_WB: RegWrite = ~Overflow;
      MEM_RD: begin
        IorD    = 1'b1;
        MemRead = 1'b1;
      end
      MEM_WAIT: MDRWrite = 1'b1;
      LW_WB: begin
        RegWrite = 1'b1;
        MemToReg = 3'd1;
      end
      MEM_WR: begin
        IorD     = 1'b1;
        MemWrite = 1'b1;
      end
      BRANCH: begin
        AluSrcA = 2'd1;
        AluCtl  = 3'd2;
        MuxPC   = 3'd1;
        PCWrite = (Opcode == OP_BNE) ? ~Zero : Zero;
      end
      JUMP: begin
        MuxPC   = 3'd2;
        PCWrite = 1'b1;
      end
      JAL: begin
        RegWrite = 1'b1;
        RegDst   = 2'd2;
        MemToReg = 3'd4;
      end
      JR: begin
        MuxPC   = 3'd3;
        PCWrite = 1'b1;
      end
      LUI_WB: begin
        RegWrite = 1'b1;
        MemToReg = 3'd6;
      end
      MFHI: begin
        RegWrite = 1'b1;
        RegDst   = 2'd1;
        MemToReg = 3'd2;
      end
      MFLO: begin
        RegWrite = 1'b1;
        RegDst   = 2'd1;
        MemToReg = 3'd3;
      end
      MULT_START: MultStart = 1'b1;
      MULT_WAIT: begin
        HighWrite = MultDone;
        LowWrite  = MultDone;
      end
      // A zero divisor must never launch the divider.
      DIV_START: DivStart = ~DivZero;
      DIV_WAIT: begin
        HighWrite = DivDone;
        LowWrite  = DivDone;
      end
      EXC_OPC, EXC_OVF, EXC_DIV: begin
        // EPC <= PC - 4 rewinds the fetch increment to the faulting instruction.
        AluSrcB  = 2'd1;
        AluCtl   = 3'd2;
        EPCWrite = 1'b1;
        if (state_q == EXC_OVF)      ExcCode = 2'd1;
        else if (state_q == EXC_DIV) ExcCode = 2'd2;
        else                         ExcCode = 2'd0;
      end
      EXC_JUMP: begin
        MuxPC   = 3'd4;
        PCWrite = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_control_unit.sv
// Self-checking bench for control_unit. A trace model turns each instruction
// (plus its flag values and mult/div latency) into the expected per-cycle
// output vector sequence, FETCH through the last cycle before the next FETCH.
module tb_control_unit;

  typedef struct packed {
    logic       pcw, irw, mrd, mwr, rw, wa, wb, wao, mdrw, epcw, hiw, low, iord;
    logic [1:0] srca, srcb;
    logic [2:0] aluctl, muxpc, m2r;
    logic [1:0] regdst, exc;
    logic       ms, ds;
  } outs_t;

  typedef struct {
    logic [5:0] op, fn;
    logic       zero, ovf, dz, spur;
    int         delay;
  } ins_t;

  logic       Clock, Reset;
  logic [5:0] Opcode, Funct;
  logic       Zero, Overflow, DivZero, MultDone, DivDone;
  logic       PCWrite, IRWrite, MemRead, MemWrite, RegWrite, WriteA, WriteB, WriteAluOut;
  logic       MDRWrite, EPCWrite, HighWrite, LowWrite, IorD, MultStart, DivStart;
  logic [1:0] AluSrcA, AluSrcB, RegDst, ExcCode;
  logic [2:0] AluCtl, MuxPC, MemToReg;

  outs_t act;
  outs_t expq[$];
  outs_t actq[$];
  int    checks = 0;
  int    errors = 0;

  control_unit dut (
    .Clock(Clock), .Reset(Reset), .Opcode(Opcode), .Funct(Funct), .Zero(Zero),
    .Overflow(Overflow), .DivZero(DivZero), .MultDone(MultDone), .DivDone(DivDone),
    .PCWrite(PCWrite), .IRWrite(IRWrite), .MemRead(MemRead), .MemWrite(MemWrite),
    .RegWrite(RegWrite), .WriteA(WriteA), .WriteB(WriteB), .WriteAluOut(WriteAluOut),
    .MDRWrite(MDRWrite), .EPCWrite(EPCWrite), .HighWrite(HighWrite), .LowWrite(LowWrite),
    .IorD(IorD), .AluSrcA(AluSrcA), .AluSrcB(AluSrcB), .AluCtl(AluCtl), .MuxPC(MuxPC),
    .MemToReg(MemToReg), .RegDst(RegDst), .ExcCode(ExcCode), .MultStart(MultStart),
    .DivStart(DivStart)
  );

  assign act = {PCWrite, IRWrite, MemRead, MemWrite, RegWrite, WriteA, WriteB, WriteAluOut,
                MDRWrite, EPCWrite, HighWrite, LowWrite, IorD, AluSrcA, AluSrcB, AluCtl,
                MuxPC, MemToReg, RegDst, ExcCode, MultStart, DivStart};

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  function automatic ins_t mk(logic [5:0] op, logic [5:0] fn, logic zero, logic ovf,
                              logic dz, int delay, logic spur);
    ins_t i;
    i.op = op; i.fn = fn; i.zero = zero; i.ovf = ovf; i.dz = dz;
    i.delay = delay; i.spur = spur;
    return i;
  endfunction

  function automatic outs_t fetch_vec();
    outs_t o = '0;
    o.mrd = 1; o.srcb = 2'd1; o.aluctl = 3'd1; o.pcw = 1;
    return o;
  endfunction

  task automatic push_exc(input logic [1:0] code);
    outs_t o;
    o = '0; o.srcb = 2'd1; o.aluctl = 3'd2; o.epcw = 1; o.exc = code; expq.push_back(o);
    o = '0; o.muxpc = 3'd4; o.pcw = 1; expq.push_back(o);
  endtask

  // Append the expected trace of one instruction to expq.
  task automatic model(input ins_t i);
    outs_t o;
    expq.push_back(fetch_vec());
    o = '0; o.irw = 1; expq.push_back(o);
    o = '0; o.wa = 1; o.wb = 1; o.wao = 1; o.srcb = 2'd3; o.aluctl = 3'd1; expq.push_back(o);
    if (i.op == 6'h00) begin
      case (i.fn)
        6'h20, 6'h22, 6'h24, 6'h2A: begin
          o = '0; o.srca = 2'd1; o.wao = 1;
          o.aluctl = (i.fn == 6'h22) ? 3'd2 : (i.fn == 6'h24) ? 3'd3 :
                     (i.fn == 6'h2A) ? 3'd7 : 3'd1;
          expq.push_back(o);
          if (i.ovf && (i.fn == 6'h20 || i.fn == 6'h22)) push_exc(2'd1);
          else begin o = '0; o.rw = !i.ovf; o.regdst = 2'd1; expq.push_back(o); end
        end
        6'h08: begin o = '0; o.muxpc = 3'd3; o.pcw = 1; expq.push_back(o); end
        6'h10: begin o = '0; o.rw = 1; o.regdst = 2'd1; o.m2r = 3'd2; expq.push_back(o); end
        6'h12: begin o = '0; o.rw = 1; o.regdst = 2'd1; o.m2r = 3'd3; expq.push_back(o); end
        6'h18, 6'h1A: begin
          if (i.fn == 6'h1A && i.dz) begin
            expq.push_back('0);
            push_exc(2'd2);
          end else begin
            o = '0; o.ms = (i.fn == 6'h18); o.ds = (i.fn == 6'h1A); expq.push_back(o);
            for (int k = 0; k < i.delay; k++) expq.push_back('0);
            o = '0; o.hiw = 1; o.low = 1; expq.push_back(o);
          end
        end
        default: push_exc(2'd0);
      endcase
    end else begin
      case (i.op)
        6'h08: begin
          o = '0; o.srca = 2'd1; o.srcb = 2'd2; o.aluctl = 3'd1; o.wao = 1; expq.push_back(o);
          if (i.ovf) push_exc(2'd1);
          else begin o = '0; o.rw = 1; expq.push_back(o); end
        end
        6'h04, 6'h05: begin
          o = '0; o.srca = 2'd1; o.aluctl = 3'd2; o.muxpc = 3'd1;
          o.pcw = (i.op == 6'h04) ? i.zero : !i.zero;
          expq.push_back(o);
        end
        6'h23, 6'h2B: begin
          o = '0; o.srca = 2'd1; o.srcb = 2'd2; o.aluctl = 3'd1; o.wao = 1; expq.push_back(o);
          if (i.op == 6'h23) begin
            o = '0; o.iord = 1; o.mrd = 1; expq.push_back(o);
            o = '0; o.mdrw = 1; expq.push_back(o);
            o = '0; o.rw = 1; o.m2r = 3'd1; expq.push_back(o);
          end else begin
            o = '0; o.iord = 1; o.mwr = 1; expq.push_back(o);
          end
        end
        6'h0F: begin o = '0; o.rw = 1; o.m2r = 3'd6; expq.push_back(o); end
        6'h02, 6'h03: begin
          if (i.op == 6'h03) begin
            o = '0; o.rw = 1; o.regdst = 2'd2; o.m2r = 3'd4; expq.push_back(o);
          end
          o = '0; o.muxpc = 3'd2; o.pcw = 1; expq.push_back(o);
        end
        default: push_exc(2'd0);
      endcase
    end
  endtask

  // Drive one instruction from FETCH and capture one output vector per cycle.
  task automatic run_instr(input ins_t i);
    int  n0, n;
    bit  is_mult, is_div;
    n0 = expq.size();
    model(i);
    n = expq.size() - n0;
    is_mult = (i.op == 6'h00) && (i.fn == 6'h18);
    is_div  = (i.op == 6'h00) && (i.fn == 6'h1A);
    Opcode = i.op; Funct = i.fn; Zero = i.zero; Overflow = i.ovf; DivZero = i.dz;
    for (int c = 0; c < n; c++) begin
      MultDone = (is_mult && c == 4 + i.delay) || ((is_mult || is_div) && i.spur && (c == 2 || c == 3));
      DivDone  = (is_div && c == 4 + i.delay) || ((is_mult || is_div) && i.spur && (c == 2 || c == 3));
      @(negedge Clock);
      actq.push_back(act);
      @(posedge Clock);
      #1;
    end
    MultDone = 1'b0;
    DivDone  = 1'b0;
  endtask

  task automatic test_reset();
    outs_t e;
    Reset = 1'b1; Opcode = '0; Funct = '0; Zero = 0; Overflow = 0; DivZero = 0;
    MultDone = 0; DivDone = 0;
    for (int c = 0; c < 3; c++) begin
      @(negedge Clock);
      checks++;
      if (act !== 32'h0) begin
        errors++;
        $display("FAIL reset_hold cycle %0d: got %h expected %h", c, act, 32'h0);
      end
    end
    Reset = 1'b0;
    #1;
    checks++;
    if (act !== 32'h0) begin
      errors++;
      $display("FAIL reset_state: got %h expected %h", act, 32'h0);
    end
    @(posedge Clock);
    #1;
    e = fetch_vec();
    checks++;
    if (act !== e) begin
      errors++;
      $display("FAIL reset_to_fetch: got %h expected %h", act, e);
    end
  endtask

  task automatic test_alu();
    expq.delete(); actq.delete();
    run_instr(mk(6'h00, 6'h20, 0, 0, 0, 0, 0));
    run_instr(mk(6'h00, 6'h22, 1, 0, 0, 0, 0));
    run_instr(mk(6'h00, 6'h24, 0, 0, 0, 0, 0));
    run_instr(mk(6'h00, 6'h2A, 0, 0, 0, 0, 0));
    run_instr(mk(6'h08, 6'h3F, 0, 0, 0, 0, 0));
    for (int k = 0; k < expq.size(); k++) begin
      checks++;
      if (actq[k] !== expq[k]) begin
        errors++;
        $display("FAIL alu cycle %0d: got %h expected %h", k, actq[k], expq[k]);
      end
    end
  endtask

  task automatic test_overflow();
    expq.delete(); actq.delete();
    run_instr(mk(6'h00, 6'h20, 0, 1, 0, 0, 0));
    run_instr(mk(6'h00, 6'h22, 0, 1, 0, 0, 0));
    run_instr(mk(6'h08, 6'h00, 0, 1, 0, 0, 0));
    for (int k = 0; k < expq.size(); k++) begin
      checks++;
      if (actq[k] !== expq[k]) begin
        errors++;
        $display("FAIL overflow cycle %0d: got %h expected %h", k, actq[k], expq[k]);
      end
    end
  endtask

  task automatic test_memory();
    expq.delete(); actq.delete();
    run_instr(mk(6'h23, 6'h11, 0, 0, 0, 0, 0));
    run_instr(mk(6'h2B, 6'h05, 0, 0, 0, 0, 0));
    for (int k = 0; k < expq.size(); k++) begin
      checks++;
      if (actq[k] !== expq[k]) begin
        errors++;
        $display("FAIL memory cycle %0d: got %h expected %h", k, actq[k], expq[k]);
      end
    end
  endtask

  task automatic test_branch();
    expq.delete(); actq.delete();
    run_instr(mk(6'h04, 6'h00, 0, 0, 0, 0, 0));
    run_instr(mk(6'h04, 6'h00, 1, 0, 0, 0, 0));
    run_instr(mk(6'h05, 6'h00, 0, 0, 0, 0, 0));
    run_instr(mk(6'h05, 6'h00, 1, 0, 0, 0, 0));
    for (int k = 0; k < expq.size(); k++) begin
      checks++;
      if (actq[k] !== expq[k]) begin
        errors++;
        $display("FAIL branch cycle %0d: got %h expected %h", k, actq[k], expq[k]);
      end
    end
  endtask

  task automatic test_jumps();
    expq.delete(); actq.delete();
    run_instr(mk(6'h02, 6'h00, 0, 0, 0, 0, 0));
    run_instr(mk(6'h03, 6'h00, 0, 0, 0, 0, 0));
    run_instr(mk(6'h00, 6'h08, 0, 0, 0, 0, 0));
    run_instr(mk(6'h0F, 6'h00, 0, 0, 0, 0, 0));
    run_instr(mk(6'h00, 6'h10, 0, 0, 0, 0, 0));
    run_instr(mk(6'h00, 6'h12, 0, 0, 0, 0, 0));
    for (int k = 0; k < expq.size(); k++) begin
      checks++;
      if (actq[k] !== expq[k]) begin
        errors++;
        $display("FAIL jumps cycle %0d: got %h expected %h", k, actq[k], expq[k]);
      end
    end
  endtask

  task automatic test_muldiv();
    expq.delete(); actq.delete();
    // Done arrives 10 cycles after MultStart.
    run_instr(mk(6'h00, 6'h18, 0, 0, 0, 9, 0));
    run_instr(mk(6'h00, 6'h18, 0, 0, 0, 0, 1));
    run_instr(mk(6'h00, 6'h1A, 0, 0, 0, 3, 1));
    run_instr(mk(6'h00, 6'h1A, 0, 0, 1, 0, 1));
    for (int k = 0; k < expq.size(); k++) begin
      checks++;
      if (actq[k] !== expq[k]) begin
        errors++;
        $display("FAIL muldiv cycle %0d: got %h expected %h", k, actq[k], expq[k]);
      end
    end
  endtask

  task automatic test_invalid();
    expq.delete(); actq.delete();
    run_instr(mk(6'h3F, 6'h00, 0, 0, 0, 0, 0));
    run_instr(mk(6'h00, 6'h3F, 0, 0, 0, 0, 0));
    run_instr(mk(6'h01, 6'h20, 0, 0, 0, 0, 0));
    for (int k = 0; k < expq.size(); k++) begin
      checks++;
      if (actq[k] !== expq[k]) begin
        errors++;
        $display("FAIL invalid cycle %0d: got %h expected %h", k, actq[k], expq[k]);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [5:0] ops[9];
    logic [5:0] fns[9];
    logic [5:0] op, fn;
    ops = '{6'h00, 6'h08, 6'h04, 6'h05, 6'h23, 6'h2B, 6'h0F, 6'h02, 6'h03};
    fns = '{6'h20, 6'h22, 6'h24, 6'h2A, 6'h08, 6'h18, 6'h1A, 6'h10, 6'h12};
    expq.delete(); actq.delete();
    for (int n = 0; n < 60; n++) begin
      if ($urandom_range(0, 9) == 0) op = 6'($urandom_range(0, 63));
      else if ($urandom_range(0, 1) == 0) op = 6'h00;
      else op = ops[$urandom_range(0, 8)];
      if ($urandom_range(0, 9) == 0) fn = 6'($urandom_range(0, 63));
      else fn = fns[$urandom_range(0, 8)];
      run_instr(mk(op, fn, 1'($urandom_range(0, 1)), ($urandom_range(0, 3) == 0),
                   ($urandom_range(0, 3) == 0), int'($urandom_range(0, 6)),
                   1'($urandom_range(0, 1))));
    end
    for (int k = 0; k < expq.size(); k++) begin
      checks++;
      if (actq[k] !== expq[k]) begin
        errors++;
        $display("FAIL random cycle %0d: got %h expected %h", k, actq[k], expq[k]);
      end
    end
  endtask

  task automatic test_reset_mid();
    outs_t e;
    Opcode = 6'h23; Funct = 6'h00; Zero = 0; Overflow = 0; DivZero = 0;
    repeat (4) @(posedge Clock);
    #2;
    e = '0; e.iord = 1; e.mrd = 1;
    checks++;
    if (act !== e) begin
      errors++;
      $display("FAIL mid_mem_rd: got %h expected %h", act, e);
    end
    Reset = 1'b1;
    #1;
    checks++;
    if (act !== 32'h0) begin
      errors++;
      $display("FAIL mid_reset_async: got %h expected %h", act, 32'h0);
    end
    @(posedge Clock);
    #1;
    checks++;
    if (act !== 32'h0) begin
      errors++;
      $display("FAIL mid_reset_held: got %h expected %h", act, 32'h0);
    end
    @(negedge Clock);
    Reset = 1'b0;
    @(posedge Clock);
    #1;
    e = fetch_vec();
    checks++;
    if (act !== e) begin
      errors++;
      $display("FAIL mid_reset_fetch: got %h expected %h", act, e);
    end
  endtask

  initial begin
    test_reset();
    test_alu();
    test_overflow();
    test_memory();
    test_branch();
    test_jumps();
    test_muldiv();
    test_invalid();
    test_back_to_back();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/control_unit.md
# control_unit

Multicycle control FSM for the MIPS-subset CPU: the sequencing side of the datapath. It decodes Opcode/Funct, walks each instruction through fetch, decode, execute, memory and writeback states, and drives every register write enable, mux select, ALU control and multiplier/divider start pulse the datapath consumes. It also handles exceptions by saving EPC and redirecting PC.

## Interface
- No parameters.
- Clock  in  1  system clock, rising edge.
- Reset  in  1  asynchronous, active-high; forces state RESET.
- Opcode  in  6  IR[31:26].
- Funct  in  6  IR[5:0].
- Zero, Overflow  in  1  ALU flags, combinational, valid in the cycle the ALU op is driven.
- DivZero  in  1  divisor == 0, sampled in DIV_START.
- MultDone, DivDone  in  1  single-cycle completion pulses.
- PCWrite, IRWrite, MemRead, MemWrite, RegWrite, WriteA, WriteB, WriteAluOut, MDRWrite, EPCWrite, HighWrite, LowWrite  out  1  write/strobe enables.
- IorD  out  1  0 PC, 1 AluOut.
- AluSrcA  out  2  0 PC, 1 A, 2 MDR.
- AluSrcB  out  2  0 B, 1 constant 4, 2 sign-extended imm, 3 imm<<2.
- AluCtl  out  3  1 add, 2 sub, 3 and, 7 slt.
- MuxPC  out  3  0 ALU result, 1 AluOut, 2 jump target, 3 A, 4 exception vector.
- MemToReg  out  3  0 AluOut, 1 MDR, 2 High, 3 Low, 4 PC, 6 imm<<16.
- RegDst  out  2  0 rt, 1 rd, 2 $31.
- ExcCode  out  2  0 invalid opcode, 1 overflow, 2 divide by zero.
- MultStart, DivStart  out  1  one-cycle start pulses.

## Operation
- Supported: R-type add, sub, and, slt, jr, mult, div, mfhi, mflo (Opcode 0); addi(0x08), beq(0x04), bne(0x05), lw(0x23), sw(0x2B), lui(0x0F), j(0x02), jal(0x03). Anything else: invalid-opcode exception.
- Outputs are Moore, decoded from state only. Exceptions: conditional enables in BRANCH (PCWrite = Zero for beq, !Zero for bne), ALU_WB/ADDI_WB (RegWrite = !Overflow), MULT_WAIT/DIV_WAIT (Hi/Lo writes on Done).
- Every output is 0 in any state that does not explicitly assert it, including during and after reset.
- States:
  - RESET -> FETCH.
  - FETCH: IorD=0, MemRead, ALU PC+4 (A=0, B=1, add), PCWrite, MuxPC=0 -> FETCH_WAIT.
  - FETCH_WAIT: IRWrite -> DECODE.
  - DECODE: WriteA, WriteB, WriteAluOut with ALU PC + imm<<2; dispatch on Opcode/Funct.
  - EXEC_R (AluCtl from Funct, WriteAluOut) -> ALU_WB (RegDst=1, MemToReg=0); overflow on add/sub goes to EXC.
  - ADDI_EXEC -> ADDI_WB (RegDst=0, MemToReg=0); overflow goes to EXC.
  - ADDR (A + sext imm, WriteAluOut); then lw: MEM_RD (IorD=1, MemRead) -> MEM_WAIT (MDRWrite) -> LW_WB (RegDst=0, MemToReg=1). sw: MEM_WR (IorD=1, MemWrite).
  - BRANCH: ALU A-B sub, MuxPC=1.
  - JUMP: MuxPC=2, PCWrite. JAL: RegWrite, RegDst=2, MemToReg=4, then JUMP. JR: MuxPC=3, PCWrite.
  - LUI_WB: RegDst=0, MemToReg=6. MFHI/MFLO: RegDst=1, MemToReg=2/3.
  - MULT_START (MultStart) -> MULT_WAIT until MultDone; HighWrite and LowWrite in the Done cycle.
  - DIV_START (DivStart; DivZero=1 goes to EXC, no DivStart) -> DIV_WAIT, same pattern as MULT_WAIT.
  - EXC: ALU PC-4 (A=0, B=1, sub), EPCWrite, ExcCode set -> EXC_JUMP: MuxPC=4, PCWrite.
  - All terminal states return to FETCH.
- RegWrite is never asserted in the same cycle as EXC entry, so an overflowing result is not committed.

## Timing
- Cycles per instruction, FETCH to FETCH: R-type ALU 5; addi 5; lw 7; sw 5; beq/bne 4; j 4; jal 5; jr 4; lui 4; mfhi/mflo 4; mult/div 5 + wait cycles; exception 2 additional cycles after the detecting state.
- Reset mid-instruction: state goes to RESET immediately and all enables drop asynchronously; no partial write occurs after the Reset edge.
- MultDone/DivDone asserted during DECODE or START are ignored; only WAIT states sample them. The wait has no timeout.

## Test plan
- Reset held 3 cycles then released: all outputs 0 during reset; RESET then FETCH with PCWrite=1, MemRead=1, AluSrcB=1, AluCtl=1.
- add (Op 0, Funct 0x20), Overflow=0: ALU_WB at cycle 5 with RegWrite=1, RegDst=1, MemToReg=0; next state FETCH.
- lw (0x23): MemRead with IorD=1 at cycle 5, MDRWrite at cycle 6, RegWrite with MemToReg=1 at cycle 7.
- beq with Zero=0 and Zero=1: PCWrite in BRANCH is 0 and 1 respectively; MuxPC=1.
- mult with MultDone arriving 10 cycles after MultStart: HighWrite=LowWrite=1 only in the Done cycle; FETCH follows.
- Opcode 0x3F: EXC with EPCWrite=1, ExcCode=0, then PCWrite=1 with MuxPC=4. add with Overflow=1: RegWrite never asserted, ExcCode=1.
